// File: rtl/hex_key_entry_pkg.sv
// rtl/hex_key_entry_pkg.sv - set-2 scan-code constants and prefix FSM state type
// Shared by the hex key entry top and its scan-code lookup.
package hex_key_entry_pkg;

  // Protocol prefixes
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BREAK = 8'hF0;

  // Command keys
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_BKSP  = 8'h66;
  localparam logic [7:0] SC_ESC   = 8'h76;

  // Hex digit make codes
  localparam logic [7:0] SC_0 = 8'h45;
  localparam logic [7:0] SC_1 = 8'h16;
  localparam logic [7:0] SC_2 = 8'h1E;
  localparam logic [7:0] SC_3 = 8'h26;
  localparam logic [7:0] SC_4 = 8'h25;
  localparam logic [7:0] SC_5 = 8'h2E;
  localparam logic [7:0] SC_6 = 8'h36;
  localparam logic [7:0] SC_7 = 8'h3D;
  localparam logic [7:0] SC_8 = 8'h3E;
  localparam logic [7:0] SC_9 = 8'h46;
  localparam logic [7:0] SC_A = 8'h1C;
  localparam logic [7:0] SC_B = 8'h32;
  localparam logic [7:0] SC_C = 8'h21;
  localparam logic [7:0] SC_D = 8'h23;
  localparam logic [7:0] SC_E = 8'h24;
  localparam logic [7:0] SC_F = 8'h2B;

  // Prefix tracking: EXT after E0, BRK after F0, EXT_BRK after E0 F0
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } kbd_state_e;

endpackage

// File: rtl/hex_key_entry_scancode_lut.sv
// rtl/hex_key_entry_scancode_lut.sv - combinational set-2 make code to hex nibble map
// Ports: code (in, 8) scan byte; is_hex (out, 1) code is a 0-9/A-F make; nib (out, 4) digit value.
module hex_scancode_lut
  import hex_key_entry_pkg::*;
(
  input  logic [7:0] code,
  output logic       is_hex,
  output logic [3:0] nib
);

  always_comb begin
    is_hex = 1'b1;
    nib    = 4'h0;
    case (code)
      SC_0:    nib = 4'h0;
      SC_1:    nib = 4'h1;
      SC_2:    nib = 4'h2;
      SC_3:    nib = 4'h3;
      SC_4:    nib = 4'h4;
      SC_5:    nib = 4'h5;
      SC_6:    nib = 4'h6;
      SC_7:    nib = 4'h7;
      SC_8:    nib = 4'h8;
      SC_9:    nib = 4'h9;
      SC_A:    nib = 4'hA;
      SC_B:    nib = 4'hB;
      SC_C:    nib = 4'hC;
      SC_D:    nib = 4'hD;
      SC_E:    nib = 4'hE;
      SC_F:    nib = 4'hF;
      default: is_hex = 1'b0;
    endcase
  end

endmodule

// File: rtl/hex_key_entry.sv
// rtl/hex_key_entry.sv - PS/2 scan-code to hex key entry with backspace, clear and commit
// Ports:
//   CLK, RST_N       clock, synchronous active-low reset
//   SCAN_CODE/VALID  byte strobe from the PS/2 receiver
//   KEY_VALUE        last committed key, first-typed digit in MSBs
//   KEY_READY        one-cycle pulse when KEY_VALUE updates
//   DIG_CNT          digits currently held in the entry register
//   LAST_NIB         most recently accepted nibble, for the display
//   ERR              one-cycle pulse on a rejected command
module hex_key_entry
  import hex_key_entry_pkg::*;
#(
  parameter int KEY_NIBBLES = 8,
  parameter int CNT_W       = 4
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic [7:0]               SCAN_CODE,
  input  logic                     SCAN_VALID,
  output logic [4*KEY_NIBBLES-1:0] KEY_VALUE,
  output logic                     KEY_READY,
  output logic [CNT_W-1:0]         DIG_CNT,
  output logic [3:0]               LAST_NIB,
  output logic                     ERR
);

  localparam int EW = 4 * KEY_NIBBLES;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(KEY_NIBBLES);

  kbd_state_e       r_state, w_state_n;
  logic [7:0]       r_held,  w_held_n;
  logic [EW-1:0]    r_entry, w_entry_n;
  logic [CNT_W-1:0] r_cnt,   w_cnt_n;
  logic [3:0]       r_last,  w_last_n;
  logic [EW-1:0]    r_key,   w_key_n;
  logic             r_ready, w_ready_n;
  logic             r_err,   w_err_n;

  logic             w_is_hex;
  logic [3:0]       w_nib;
  logic [EW-1:0]    w_entry_shl;
  logic [EW-1:0]    w_entry_shr;

  hex_scancode_lut u_lut (
    .code   (SCAN_CODE),
    .is_hex (w_is_hex),
    .nib    (w_nib)
  );

  assign w_entry_shl = {r_entry[EW-5:0], w_nib};
  assign w_entry_shr = r_entry >> 4;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state <= ST_IDLE;
      r_held  <= '0;
      r_entry <= '0;
      r_cnt   <= '0;
      r_last  <= '0;
      r_key   <= '0;
      r_ready <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_held  <= w_held_n;
      r_entry <= w_entry_n;
      r_cnt   <= w_cnt_n;
      r_last  <= w_last_n;
      r_key   <= w_key_n;
      r_ready <= w_ready_n;
      r_err   <= w_err_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_held_n  = r_held;
    w_entry_n = r_entry;
    w_cnt_n   = r_cnt;
    w_last_n  = r_last;
    w_key_n   = r_key;
    w_ready_n = 1'b0;
    w_err_n   = 1'b0;

    if (SCAN_VALID) begin
      case (r_state)
        ST_IDLE: begin
          if (SCAN_CODE == SC_EXT) begin
            w_state_n = ST_EXT;
          end else if (SCAN_CODE == SC_BREAK) begin
            w_state_n = ST_BRK;
          end else if (SCAN_CODE != r_held) begin
            // A byte equal to the held key is a typematic repeat and is dropped
            w_held_n = SCAN_CODE;
            if (w_is_hex) begin
              if (r_cnt < FULL_CNT) begin
                w_entry_n = w_entry_shl;
                w_cnt_n   = r_cnt + 1'b1;
                w_last_n  = w_nib;
              end else begin
                w_err_n = 1'b1;
              end
            end else begin
              case (SCAN_CODE)
                SC_BKSP: begin
                  if (r_cnt != '0) begin
                    w_entry_n = w_entry_shr;
                    w_cnt_n   = r_cnt - 1'b1;
                    w_last_n  = (r_cnt == CNT_W'(1)) ? 4'h0 : w_entry_shr[3:0];
                  end else begin
                    w_err_n = 1'b1;
                  end
                end
                SC_ESC: begin
                  w_entry_n = '0;
                  w_cnt_n   = '0;
                  w_last_n  = 4'h0;
                end
                SC_ENTER: begin
                  if (r_cnt == FULL_CNT) begin
                    w_key_n   = r_entry;
                    w_ready_n = 1'b1;
                    w_entry_n = '0;
                    w_cnt_n   = '0;
                    w_last_n  = 4'h0;
                  end else begin
                    w_err_n = 1'b1;
                  end
                end
                default: ;
              endcase
            end
          end
        end
        ST_BRK: begin
          // Releasing the held key re-arms it so the next press is a fresh make
          if (SCAN_CODE == r_held) begin
            w_held_n = '0;
          end
          w_state_n = ST_IDLE;
        end
        ST_EXT: begin
          w_state_n = (SCAN_CODE == SC_BREAK) ? ST_EXT_BRK : ST_IDLE;
        end
        ST_EXT_BRK: begin
          w_state_n = ST_IDLE;
        end
        default: w_state_n = ST_IDLE;
      endcase
    end
  end

  assign KEY_VALUE = r_key;
  assign KEY_READY = r_ready;
  assign DIG_CNT   = r_cnt;
  assign LAST_NIB  = r_last;
  assign ERR       = r_err;

endmodule
